// File: rtl/ifex_pkg.sv
// rtl/ifex_pkg.sv - Opcode, function, field and FSM definitions shared by ifex_mc
package ifex_pkg;

    localparam logic [3:0] OP_REG       = 4'h0;
    localparam logic [3:0] OP_LDI       = 4'h1;
    localparam logic [3:0] OP_ADDI      = 4'h2;
    localparam logic [3:0] OP_BEZ       = 4'h3;
    localparam logic [3:0] OP_BEZD      = 4'h4;
    localparam logic [3:0] OP_BNZ       = 4'h5;
    localparam logic [3:0] OP_BNZD      = 4'h6;
    localparam logic [3:0] OP_SET_LD    = 4'h7;
    localparam logic [3:0] OP_SET_ST    = 4'h8;
    localparam logic [3:0] OP_LD_ST_ADD = 4'h9;

    localparam logic [3:0] FN_NOP   = 4'h0;
    localparam logic [3:0] FN_ADD   = 4'h1;
    localparam logic [3:0] FN_SUB   = 4'h2;
    localparam logic [3:0] FN_MV    = 4'h3;
    localparam logic [3:0] FN_CHSEL = 4'hD;
    localparam logic [3:0] FN_DELAY = 4'hE;
    localparam logic [3:0] FN_DONE  = 4'hF;

    localparam int F_OP_LSB = 12;
    localparam int F_D_LSB  = 8;
    localparam int F_S_LSB  = 4;
    localparam int F_F_LSB  = 0;
    localparam int F_W      = 4;
    localparam int IMM_W    = 8;
    localparam int SA_LSB   = 4;
    localparam int SA_W     = 8;
    localparam int DNUM_W   = 4;

    localparam logic [15:0] INSN_NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ifex_mc_rfile.sv
// rtl/ifex_mc_rfile.sv - Scalar register file (2R/1W) plus per-channel sa/dnum arrays
module ifex_mc_rfile #(
    parameter int DW   = 16,
    parameter int RA_W = 4,
    parameter int NCH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RA_W-1:0]          ra_a,
    input  logic [RA_W-1:0]          rb_a,
    output logic [DW-1:0]            ra_d,
    output logic [DW-1:0]            rb_d,
    input  logic                     we,
    input  logic [RA_W-1:0]          wa,
    input  logic [DW-1:0]            wd,
    input  logic [NCH-1:0]           sa_ld_we,
    input  logic [NCH-1:0]           sa_st_we,
    input  logic [NCH-1:0]           dnum_ld_we,
    input  logic [NCH-1:0]           dnum_st_we,
    input  logic [DW-1:0]            sa_ld_wd,
    input  logic [DW-1:0]            sa_st_wd,
    input  logic [DW-1:0]            dnum_wd,
    output logic [NCH-1:0][DW-1:0]   sa_ld,
    output logic [NCH-1:0][DW-1:0]   sa_st,
    output logic [NCH-1:0][DW-1:0]   dnum_ld,
    output logic [NCH-1:0][DW-1:0]   dnum_st
);

    localparam int NREG = 1 << RA_W;

    logic [NREG-1:0][DW-1:0] regs;

    assign ra_d = regs[ra_a];
    assign rb_d = regs[rb_a];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs    <= '0;
            sa_ld   <= '0;
            sa_st   <= '0;
            dnum_ld <= '0;
            dnum_st <= '0;
        end else begin
            if (we) regs[wa] <= wd;
            for (int i = 0; i < NCH; i++) begin
                if (sa_ld_we[i])   sa_ld[i]   <= sa_ld_wd;
                if (sa_st_we[i])   sa_st[i]   <= sa_st_wd;
                if (dnum_ld_we[i]) dnum_ld[i] <= dnum_wd;
                if (dnum_st_we[i]) dnum_st[i] <= dnum_wd;
            end
        end
    end

endmodule

// File: rtl/ifex_mc.sv
// rtl/ifex_mc.sv - Multi-channel fetch/execute sequencer; IFEX_PERF_EN adds cycle/stall counters
module ifex_mc
    import ifex_pkg::*;
#(
    parameter int DW    = 16,
    parameter int RA_W  = 4,
    parameter int IA_W  = 8,
    parameter int NCH   = 2,
    parameter int DLY_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_working,
    output logic [IA_W-1:0]  o_imem_a,
    input  logic [15:0]      i_imem_rd,
    input  logic [NCH-1:0]   i_ch_busy,
    output logic [NCH-1:0]   o_ldst_vld,
    output logic [DW-1:0]    o_ld_addr,
    output logic [DW-1:0]    o_st_addr,
    output logic [3:0]       o_func_ld,
    output logic [3:0]       o_func_st,
    output logic [DLY_W-1:0] o_delay,
    output logic             o_first_set,
    output logic             o_running,
    output logic             o_done,
    output logic [3:0]       o_pc_dbg
`ifdef IFEX_PERF_EN
    ,
    output logic [15:0]      o_cyc_cnt,
    output logic [15:0]      o_stall_cnt
`endif
);

    localparam int         CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [4:0] NCH_V = 5'(NCH);

    state_t              state, state_nxt;
    logic                run_q, run_edge, exec;
    logic [IA_W-1:0]     pc, pc_nxt, br_off;
    logic [CH_W-1:0]     ch_sel, ch_idx;
    logic [15:0]         ins;
    logic [3:0]          op, fd, fs, ff;
    logic [DW-1:0]       imm_d, rd_val, rs_val, rd_dec;
    logic                ch_ok;

    logic                rf_we, taken, stall, issue, done_op, delay_op, chsel_op;
    logic [DW-1:0]       rf_wd, sa_ld_wd, sa_st_wd, dnum_wd;
    logic [NCH-1:0]      sa_ld_we, sa_st_we, dnum_ld_we, dnum_st_we;
    logic [NCH-1:0][DW-1:0] sa_ld, sa_st, dnum_ld, dnum_st;

    assign run_edge  = i_run & ~run_q;
    assign exec      = (state == ST_RUN) && !run_edge;
    assign ins       = exec ? i_imem_rd : INSN_NOP;
    assign op        = ins[F_OP_LSB +: F_W];
    assign fd        = ins[F_D_LSB +: F_W];
    assign fs        = ins[F_S_LSB +: F_W];
    assign ff        = ins[F_F_LSB +: F_W];
    assign imm_d     = DW'($signed(ins[IMM_W-1:0]));
    assign br_off    = IA_W'($signed(ins[IMM_W-1:0]));
    assign rd_dec    = rd_val - DW'(1);
    assign ch_ok     = {1'b0, fd} < NCH_V;
    assign ch_idx    = fd[CH_W-1:0];

    assign o_imem_a  = pc;
    assign o_pc_dbg  = pc[3:0];
    assign o_running = (state == ST_RUN);

    ifex_mc_rfile #(.DW(DW), .RA_W(RA_W), .NCH(NCH)) u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra_a       (fd[RA_W-1:0]),
        .rb_a       (fs[RA_W-1:0]),
        .ra_d       (rd_val),
        .rb_d       (rs_val),
        .we         (rf_we),
        .wa         (fd[RA_W-1:0]),
        .wd         (rf_wd),
        .sa_ld_we   (sa_ld_we),
        .sa_st_we   (sa_st_we),
        .dnum_ld_we (dnum_ld_we),
        .dnum_st_we (dnum_st_we),
        .sa_ld_wd   (sa_ld_wd),
        .sa_st_wd   (sa_st_wd),
        .dnum_wd    (dnum_wd),
        .sa_ld      (sa_ld),
        .sa_st      (sa_st),
        .dnum_ld    (dnum_ld),
        .dnum_st    (dnum_st)
    );

    // Decode; a gated-off instruction word is NOP, so nothing here needs to know the FSM state.
    always_comb begin
        rf_we      = 1'b0;
        rf_wd      = '0;
        taken      = 1'b0;
        stall      = 1'b0;
        issue      = 1'b0;
        done_op    = 1'b0;
        delay_op   = 1'b0;
        chsel_op   = 1'b0;
        sa_ld_we   = '0;
        sa_st_we   = '0;
        dnum_ld_we = '0;
        dnum_st_we = '0;
        sa_ld_wd   = '0;
        sa_st_wd   = '0;
        dnum_wd    = DW'(ins[DNUM_W-1:0]);
        case (op)
            OP_REG: begin
                case (ff)
                    FN_NOP:   ;
                    FN_ADD:   begin rf_we = 1'b1; rf_wd = rd_val + rs_val; end
                    FN_SUB:   begin rf_we = 1'b1; rf_wd = rd_val - rs_val; end
                    FN_MV:    begin rf_we = 1'b1; rf_wd = rs_val; end
                    FN_CHSEL: chsel_op = 1'b1;
                    FN_DELAY: delay_op = 1'b1;
                    FN_DONE:  done_op  = 1'b1;
                    default:  ;
                endcase
            end
            OP_LDI:  begin rf_we = 1'b1; rf_wd = imm_d; end
            OP_ADDI: begin rf_we = 1'b1; rf_wd = rd_val + imm_d; end
            OP_BEZ:  taken = (rd_val == '0);
            OP_BNZ:  taken = (rd_val != '0);
            OP_BEZD: begin rf_we = 1'b1; rf_wd = rd_dec; taken = (rd_dec == '0); end
            OP_BNZD: begin rf_we = 1'b1; rf_wd = rd_dec; taken = (rd_dec != '0); end
            OP_SET_LD: begin
                sa_ld_we[ch_sel]   = 1'b1;
                dnum_ld_we[ch_sel] = 1'b1;
                sa_ld_wd           = DW'(ins[SA_LSB +: SA_W]);
            end
            OP_SET_ST: begin
                sa_st_we[ch_sel]   = 1'b1;
                dnum_st_we[ch_sel] = 1'b1;
                sa_st_wd           = DW'(ins[SA_LSB +: SA_W]);
            end
            OP_LD_ST_ADD: begin
                if (ch_ok) begin
                    if (i_ch_busy[ch_idx]) begin
                        stall = 1'b1;
                    end else begin
                        issue            = 1'b1;
                        sa_ld_we[ch_idx] = 1'b1;
                        sa_st_we[ch_idx] = 1'b1;
                        sa_ld_wd         = sa_ld[ch_idx] + dnum_ld[ch_idx];
                        sa_st_wd         = sa_st[ch_idx] + dnum_st[ch_idx];
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            ST_RUN: begin
                if (done_op) state_nxt = ST_DRAIN;
                if (taken)
                    pc_nxt = pc + IA_W'(1) + br_off;
                else if (!done_op && !stall)
                    pc_nxt = pc + IA_W'(1);
            end
            ST_DRAIN: if (!i_working) state_nxt = ST_IDLE;
            default: ;
        endcase
        if (run_edge) begin
            state_nxt = ST_RUN;
            pc_nxt    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            run_q       <= 1'b0;
            pc          <= '0;
            ch_sel      <= '0;
            o_done      <= 1'b0;
            o_ldst_vld  <= '0;
            o_ld_addr   <= '0;
            o_st_addr   <= '0;
            o_func_ld   <= '0;
            o_func_st   <= '0;
            o_delay     <= '1;
            o_first_set <= 1'b0;
        end else begin
            state       <= state_nxt;
            run_q       <= i_run;
            pc          <= pc_nxt;
            o_first_set <= delay_op;
            o_ldst_vld  <= issue ? (NCH'(1) << ch_idx) : '0;
            if (run_edge) begin
                ch_sel <= '0;
                o_done <= 1'b0;
            end else begin
                if (chsel_op && ch_ok) ch_sel <= ch_idx;
                if (state == ST_DRAIN && !i_working) o_done <= 1'b1;
            end
            if (issue) begin
                o_ld_addr <= sa_ld[ch_idx];
                o_st_addr <= sa_st[ch_idx];
                o_func_ld <= fs;
                o_func_st <= ff;
            end
            if (delay_op) o_delay <= DLY_W'(fd);
        end
    end

`ifdef IFEX_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cyc_cnt   <= '0;
            o_stall_cnt <= '0;
        end else if (run_edge) begin
            o_cyc_cnt   <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (state == ST_RUN && o_cyc_cnt != 16'hFFFF) o_cyc_cnt <= o_cyc_cnt + 16'd1;
            if (stall && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifex_mc.sv
// tb/tb_ifex_mc.sv - Directed and randomized self-checking bench for ifex_mc
module tb_ifex_mc;

    localparam int DW = 16, RA_W = 4, IA_W = 8, NCH = 2, DLY_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, i_run, i_working;
    logic [IA_W-1:0]  o_imem_a;
    logic [15:0]      i_imem_rd;
    logic [NCH-1:0]   i_ch_busy, o_ldst_vld;
    logic [DW-1:0]    o_ld_addr, o_st_addr;
    logic [3:0]       o_func_ld, o_func_st, o_pc_dbg;
    logic [DLY_W-1:0] o_delay;
    logic             o_first_set, o_running, o_done;
`ifdef IFEX_PERF_EN
    logic [15:0]      o_cyc_cnt, o_stall_cnt;
`endif

    logic [15:0] imem [256];
    int n_chk = 0, n_pass = 0;

    assign i_imem_rd = imem[o_imem_a];
    always #5 clk = ~clk;

    ifex_mc #(.DW(DW), .RA_W(RA_W), .IA_W(IA_W), .NCH(NCH), .DLY_W(DLY_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_working(i_working),
        .o_imem_a(o_imem_a), .i_imem_rd(i_imem_rd), .i_ch_busy(i_ch_busy),
        .o_ldst_vld(o_ldst_vld), .o_ld_addr(o_ld_addr), .o_st_addr(o_st_addr),
        .o_func_ld(o_func_ld), .o_func_st(o_func_st), .o_delay(o_delay),
        .o_first_set(o_first_set), .o_running(o_running), .o_done(o_done),
        .o_pc_dbg(o_pc_dbg)
`ifdef IFEX_PERF_EN
        , .o_cyc_cnt(o_cyc_cnt), .o_stall_cnt(o_stall_cnt)
`endif
    );

    function automatic logic [15:0] insr(input int op, input int d, input int s, input int f);
        return {op[3:0], d[3:0], s[3:0], f[3:0]};
    endfunction

    function automatic logic [15:0] insi(input int op, input int d, input int imm);
        return {op[3:0], d[3:0], imm[7:0]};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_run = 1'b0; i_working = 1'b0; i_ch_busy = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start();
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
    endtask

    // ISA-level reference model used by the randomized test
    int          m_state;
    logic [7:0]  m_pc;
    logic [15:0] m_r [16];
    logic [15:0] m_sal [NCH], m_sas [NCH], m_dl [NCH], m_ds [NCH];
    int          m_ch;
    logic        m_run_q, m_done, m_first;
    logic [NCH-1:0] m_vld;
    logic [15:0] m_ld, m_st;
    logic [3:0]  m_fl, m_fs, m_delay;

    task automatic model_reset();
        m_state = 0; m_pc = '0; m_ch = 0; m_run_q = 0; m_done = 0; m_first = 0;
        m_vld = '0; m_ld = '0; m_st = '0; m_fl = '0; m_fs = '0; m_delay = 4'hF;
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        for (int i = 0; i < NCH; i++) begin m_sal[i] = '0; m_sas[i] = '0; m_dl[i] = '0; m_ds[i] = '0; end
    endtask

    task automatic model_step();
        logic [15:0] w, imm;
        logic [3:0]  op, f;
        int          d, s;
        logic [7:0]  npc;
        bit          edge_seen, taken;
        edge_seen = i_run && !m_run_q;
        m_run_q   = i_run;
        m_vld     = '0;
        m_first   = 1'b0;
        if (edge_seen) begin
            m_state = 1; m_pc = '0; m_done = 0; m_ch = 0;
        end else if (m_state == 2) begin
            if (!i_working) begin m_state = 0; m_done = 1'b1; end
        end else if (m_state == 1) begin
            w = imem[m_pc];
            op = w[15:12]; d = int'(w[11:8]); s = int'(w[7:4]); f = w[3:0];
            imm = {{8{w[7]}}, w[7:0]};
            npc = m_pc + 8'd1;
            taken = 0;
            case (op)
                4'h0: case (f)
                    4'h1: m_r[d] = m_r[d] + m_r[s];
                    4'h2: m_r[d] = m_r[d] - m_r[s];
                    4'h3: m_r[d] = m_r[s];
                    4'hD: if (d < NCH) m_ch = d;
                    4'hE: begin m_delay = w[11:8]; m_first = 1'b1; end
                    4'hF: begin m_state = 2; npc = m_pc; end
                    default: ;
                endcase
                4'h1: m_r[d] = imm;
                4'h2: m_r[d] = m_r[d] + imm;
                4'h3: taken = (m_r[d] == 0);
                4'h5: taken = (m_r[d] != 0);
                4'h4: begin m_r[d] = m_r[d] - 16'd1; taken = (m_r[d] == 0); end
                4'h6: begin m_r[d] = m_r[d] - 16'd1; taken = (m_r[d] != 0); end
                4'h7: begin m_sal[m_ch] = {8'h00, w[11:4]}; m_dl[m_ch] = {12'h000, w[3:0]}; end
                4'h8: begin m_sas[m_ch] = {8'h00, w[11:4]}; m_ds[m_ch] = {12'h000, w[3:0]}; end
                4'h9: if (d < NCH) begin
                    if (i_ch_busy[d]) npc = m_pc;
                    else begin
                        m_vld[d] = 1'b1; m_ld = m_sal[d]; m_st = m_sas[d];
                        m_fl = w[7:4]; m_fs = f;
                        m_sal[d] = m_sal[d] + m_dl[d];
                        m_sas[d] = m_sas[d] + m_ds[d];
                    end
                end
                default: ;
            endcase
            if (taken) npc = m_pc + 8'd1 + w[7:0];
            m_pc = npc;
        end
    endtask

    task automatic test_reset();
        clear_imem();
        imem[0] = insi(1, 1, 5);
        do_reset();
        n_chk++;
        if ({o_imem_a, o_ldst_vld, o_ld_addr, o_st_addr, o_func_ld, o_func_st, o_first_set, o_running, o_done, o_pc_dbg} !== '0)
            $display("FAIL reset_outputs: got pc=%h vld=%b ld=%h st=%h run=%b done=%b, expected all zero",
                     o_imem_a, o_ldst_vld, o_ld_addr, o_st_addr, o_running, o_done);
        else n_pass++;
        n_chk++;
        if (o_delay !== 4'hF) $display("FAIL reset_delay: got %h expected f", o_delay);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({o_imem_a, o_running} !== 9'd0) $display("FAIL idle_hold: got pc=%h run=%b expected pc=00 run=0", o_imem_a, o_running);
        else n_pass++;
    endtask

    task automatic test_alu();
        clear_imem();
        imem[0] = insi(1, 1, 5);
        imem[1] = insi(1, 2, 3);
        imem[2] = insr(0, 1, 2, 1);
        imem[3] = insr(0, 0, 0, 15);
        do_reset();
        start();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({o_imem_a, o_running, o_done} !== {8'd3, 1'b1, 1'b0})
            $display("FAIL alu_done_fetch: got pc=%h run=%b done=%b expected pc=03 run=1 done=0", o_imem_a, o_running, o_done);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({o_running, o_done} !== 2'b00) $display("FAIL alu_drain: got run=%b done=%b expected 0 0", o_running, o_done);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({o_running, o_done, o_pc_dbg} !== {1'b0, 1'b1, 4'd3})
            $display("FAIL alu_done: got run=%b done=%b pcdbg=%h expected run=0 done=1 pcdbg=3", o_running, o_done, o_pc_dbg);
        else n_pass++;
        n_chk++;
        if ({dut.u_rf.regs[1], dut.u_rf.regs[2]} !== {16'd8, 16'd3})
            $display("FAIL alu_regs: got r1=%h r2=%h expected r1=0008 r2=0003", dut.u_rf.regs[1], dut.u_rf.regs[2]);
        else n_pass++;
    endtask

    task automatic test_loop();
        clear_imem();
        imem[0] = insi(1, 3, 3);
        imem[1] = insi(6, 3, 8'hFF);
        imem[2] = insr(0, 0, 0, 15);
        do_reset();
        start();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (o_imem_a !== 8'd1) $display("FAIL loop_body%0d: got pc=%h expected 01", k, o_imem_a);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++;
        if ({o_imem_a, dut.u_rf.regs[3]} !== {8'd2, 16'd0})
            $display("FAIL loop_exit: got pc=%h r3=%h expected pc=02 r3=0000", o_imem_a, dut.u_rf.regs[3]);
        else n_pass++;
    endtask

    task automatic test_channel();
        clear_imem();
        imem[0] = insr(0, 1, 0, 13);
        imem[1] = insr(0, 3, 0, 13);
        imem[2] = insi(7, 2, 8'h04);
        imem[3] = insi(8, 4, 8'h02);
        imem[4] = insr(9, 1, 5, 6);
        imem[5] = insr(9, 1, 5, 6);
        imem[6] = insr(9, 3, 5, 6);
        imem[7] = insr(0, 0, 0, 15);
        do_reset();
        start();
        repeat (5) @(negedge clk);
        n_chk++;
        if ({o_ldst_vld, o_ld_addr, o_st_addr, o_func_ld, o_func_st} !== {2'b10, 16'h0020, 16'h0040, 4'd5, 4'd6})
            $display("FAIL ch_issue1: got vld=%b ld=%h st=%h fl=%h fs=%h expected 10 0020 0040 5 6",
                     o_ldst_vld, o_ld_addr, o_st_addr, o_func_ld, o_func_st);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({o_ldst_vld, o_ld_addr, o_st_addr} !== {2'b10, 16'h0024, 16'h0042})
            $display("FAIL ch_issue2: got vld=%b ld=%h st=%h expected 10 0024 0042", o_ldst_vld, o_ld_addr, o_st_addr);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({o_ldst_vld, o_ld_addr, o_imem_a} !== {2'b00, 16'h0024, 8'd7})
            $display("FAIL ch_hold: got vld=%b ld=%h pc=%h expected 00 0024 07", o_ldst_vld, o_ld_addr, o_imem_a);
        else n_pass++;
    endtask

    task automatic test_stall();
        clear_imem();
        imem[0] = insi(7, 1, 8'h01);
        imem[1] = insr(9, 0, 1, 2);
        imem[2] = insr(0, 0, 0, 15);
        do_reset();
        start();
        i_ch_busy = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_chk++;
            if ({o_imem_a, o_ldst_vld} !== {8'd1, 2'b00})
                $display("FAIL stall_hold%0d: got pc=%h vld=%b expected 01 00", k, o_imem_a, o_ldst_vld);
            else n_pass++;
        end
        i_ch_busy = 2'b00;
        @(negedge clk);
        n_chk++;
        if ({o_imem_a, o_ldst_vld, o_ld_addr, o_func_ld, o_func_st} !== {8'd2, 2'b01, 16'h0010, 4'd1, 4'd2})
            $display("FAIL stall_release: got pc=%h vld=%b ld=%h fl=%h fs=%h expected 02 01 0010 1 2",
                     o_imem_a, o_ldst_vld, o_ld_addr, o_func_ld, o_func_st);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (o_ldst_vld !== 2'b00) $display("FAIL stall_single_pulse: got vld=%b expected 00", o_ldst_vld);
        else n_pass++;
    endtask

    task automatic test_drain();
        clear_imem();
        imem[0] = insr(0, 0, 0, 15);
        do_reset();
        i_working = 1'b1;
        start();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_chk++;
            if ({o_running, o_done} !== 2'b00) $display("FAIL drain_wait%0d: got run=%b done=%b expected 0 0", k, o_running, o_done);
            else n_pass++;
        end
        i_working = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({o_done, o_imem_a} !== {1'b1, 8'd0}) $display("FAIL drain_done: got done=%b pc=%h expected 1 00", o_done, o_imem_a);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_chk++;
        if (o_done !== 1'b1) $display("FAIL done_sticky: got %b expected 1", o_done);
        else n_pass++;
    endtask

    task automatic test_restart_reset();
        clear_imem();
        imem[0] = insr(0, 3, 0, 14);
        imem[1] = insi(1, 3, 8'h40);
        imem[2] = insi(6, 3, 8'hFF);
        imem[3] = insr(0, 0, 0, 15);
        do_reset();
        i_working = 1'b1;
        start();
        @(negedge clk);
        n_chk++;
        if ({o_delay, o_first_set} !== {4'd3, 1'b1}) $display("FAIL delay_set: got delay=%h first=%b expected 3 1", o_delay, o_first_set);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (o_first_set !== 1'b0) $display("FAIL first_set_pulse: got %b expected 0", o_first_set);
        else n_pass++;
        for (int k = 0; k < 300 && o_running; k++) @(negedge clk);
        n_chk++;
        if ({o_running, o_done, o_imem_a} !== {1'b0, 1'b0, 8'd3})
            $display("FAIL drain_entry: got run=%b done=%b pc=%h expected 0 0 03", o_running, o_done, o_imem_a);
        else n_pass++;
        start();
        n_chk++;
        if ({o_running, o_done, o_imem_a} !== {1'b1, 1'b0, 8'd0})
            $display("FAIL restart_in_drain: got run=%b done=%b pc=%h expected 1 0 00", o_running, o_done, o_imem_a);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_chk++;
        if ({o_running, o_imem_a} !== {1'b1, 8'd2}) $display("FAIL restart_loop: got run=%b pc=%h expected 1 02", o_running, o_imem_a);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({o_imem_a, o_ldst_vld, o_ld_addr, o_st_addr, o_func_ld, o_func_st, o_delay, o_first_set, o_running, o_done, o_pc_dbg}
            !== {8'd0, 2'b00, 16'd0, 16'd0, 4'd0, 4'd0, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0})
            $display("FAIL async_reset: got pc=%h delay=%h run=%b done=%b first=%b expected 00 f 0 0 0",
                     o_imem_a, o_delay, o_running, o_done, o_first_set);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({o_running, o_done, o_imem_a, o_first_set, dut.u_rf.regs[3]} !== {1'b0, 1'b0, 8'd0, 1'b0, 16'd0})
            $display("FAIL post_reset_idle: got run=%b done=%b pc=%h first=%b r3=%h expected 0 0 00 0 0000",
                     o_running, o_done, o_imem_a, o_first_set, dut.u_rf.regs[3]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 256; i++) begin
                imem[i] = 16'($urandom);
                imem[i][15:12] = 4'($urandom_range(0, 10));
            end
            do_reset();
            model_reset();
            for (int c = 0; c < 500; c++) begin
                i_ch_busy = NCH'($urandom);
                i_working = ($urandom_range(0, 3) != 0);
                i_run     = (c == 0) || ($urandom_range(0, 60) == 0);
                model_step();
                @(negedge clk);
                n_chk++;
                if ({o_imem_a, o_ldst_vld, o_ld_addr, o_st_addr, o_func_ld, o_func_st, o_delay, o_first_set, o_running, o_done, o_pc_dbg}
                    !== {m_pc, m_vld, m_ld, m_st, m_fl, m_fs, m_delay, m_first, (m_state == 1), m_done, m_pc[3:0]})
                    $display("FAIL random r%0d c%0d: got pc=%h vld=%b ld=%h st=%h fl=%h fs=%h dly=%h fs1=%b run=%b done=%b expected pc=%h vld=%b ld=%h st=%h fl=%h fs=%h dly=%h fs1=%b run=%b done=%b",
                             round, c, o_imem_a, o_ldst_vld, o_ld_addr, o_st_addr, o_func_ld, o_func_st, o_delay, o_first_set, o_running, o_done,
                             m_pc, m_vld, m_ld, m_st, m_fl, m_fs, m_delay, m_first, (m_state == 1), m_done);
                else n_pass++;
            end
            i_run = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; i_run = 1'b0; i_working = 1'b0; i_ch_busy = '0;
        clear_imem();
        test_reset();
        test_alu();
        test_loop();
        test_channel();
        test_stall();
        test_drain();
        test_restart_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifex_mc.md
Name: ifex_mc

Overview:
- Multi-channel successor to the single-pair fetch/execute sequencer in the SMA controller.
- Fetches 16-bit instructions from an external instruction memory and executes scalar ALU and branch ops on an internal register file.
- Drives NCH independent load/store address-stream channels. Adds per-channel back-pressure stalls and an explicit run/drain/done FSM.

Parameters:
DW, 16, datapath and register width
RA_W, 4, register address width; 2^RA_W registers
IA_W, 8, instruction address width
NCH, 2, number of load/store channel pairs (1..16)
DLY_W, 4, delay field width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_run  in  1  run request; rising edge starts program
i_working  in  1  downstream array still busy
o_imem_a  out  IA_W  fetch address (= PC)
i_imem_rd  in  16  instruction, combinational read of o_imem_a
i_ch_busy  in  NCH  per-channel stall request
o_ldst_vld  out  NCH  one-hot pulse, channel issued
o_ld_addr  out  DW  load start address of issued channel
o_st_addr  out  DW  store start address of issued channel
o_func_ld  out  4  load function code
o_func_st  out  4  store function code
o_delay  out  DLY_W  configured delay
o_first_set  out  1  pulse, cycle after DELAY executed
o_running  out  1  FSM in RUN
o_done  out  1  program complete, sticky
o_pc_dbg  out  4  PC[3:0]

Behaviour:
- Instruction format: op[15:12], d[11:8], s[7:4], f[3:0]. imm = [7:0], sign-extended to DW for data and to IA_W for branches.
- Opcodes: REG=0, LDI=1, ADDI=2, BEZ=3, BEZD=4, BNZ=5, BNZD=6, SET_LD=7, SET_ST=8, LD_ST_ADD=9.
- REG functions: NOP=0, ADD=1, SUB=2, MV=3, CHSEL=D, DELAY=E, DONE=F. Unused codes execute as NOP.
- Rising edge of i_run is detected against a registered copy of i_run.
- FSM states:
  - IDLE: fetch is forced to NOP.
  - IDLE -> RUN on run edge: PC=0, done=0, ch_sel=0.
  - RUN -> DRAIN on DONE.
  - DRAIN: fetch is forced to NOP. DRAIN -> IDLE when i_working=0, setting o_done=1 in the same edge.
  - A run edge in any state restarts RUN and overrides everything else.
- Scalar operations: ADD rd+rs, SUB rd-rs, MV rs, LDI imm, ADDI rd+imm, each writing rd.
  - BEZD/BNZD write rd-1 and branch on (rd-1)==0 / !=0.
  - BEZ/BNZ branch on rd==0 / !=0.
  - All arithmetic is modulo 2^DW.
- PC: a taken branch loads PC+1+imm modulo 2^IA_W. Otherwise PC increments in RUN unless the instruction is DONE or the core is stalled. PC wraps from 2^IA_W-1 to 0.
- CHSEL: ch_sel <= d. An index >= NCH is ignored.
- SET_LD / SET_ST act on channel ch_sel: sa <= zero-extended [11:4], dnum <= zero-extended [3:0].
- LD_ST_ADD targets channel c=d; an index >= NCH executes as NOP.
  - If i_ch_busy[c]=1: stall. PC holds, no state written, no issue.
  - Otherwise: next cycle o_ldst_vld[c]=1 and o_ld_addr/o_st_addr carry pre-increment sa_ld[c]/sa_st[c]; o_func_ld=s, o_func_st=f. Same edge: sa_ld[c]+=dnum_ld[c] and sa_st[c]+=dnum_st[c].
  - SET_LD immediately followed by LD_ST_ADD on the same channel sees the new sa (register file written first).
- DELAY: o_delay <= d. o_first_set pulses one cycle after.
- Output registers hold their values between issues; o_ldst_vld is a single-cycle pulse.
- Reset values: o_delay all ones; all other outputs 0; registers, sa and dnum 0; FSM IDLE.
- Reset mid-operation returns the block to IDLE with no residual pulse.

Optional Feature:
IFEX_PERF_EN:
- Defined: adds outputs o_cyc_cnt[15:0] and o_stall_cnt[15:0].
  - o_cyc_cnt counts cycles in RUN; o_stall_cnt counts stall cycles.
  - Both saturate at 16'hFFFF and clear on run edge and reset.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package ifex_pkg holds: opcode and function constants, field position constants, FSM state encoding.
- One sub-module, ifex_mc_rfile: 2 read ports, 1 write port, plus the NCH-deep sa/dnum arrays with per-channel write enables.

Test Plan:
- LDI r1,5; LDI r2,3; ADD r1,r2; DONE with i_working=0 -> r1=8; o_done=1 two cycles after DONE fetch; o_running=0.
- LDI r3,3; loop BNZD r3,-1 -> body executes 3 times; r3=0; PC falls through to the next instruction.
- CHSEL 1; SET_LD sa=0x20,dnum=4; LD_ST_ADD ch1 twice -> o_ldst_vld=2'b10 twice; o_ld_addr=0x20 then 0x24.
- LD_ST_ADD ch0 with i_ch_busy[0] high for 3 cycles -> PC frozen 3 cycles; single vld pulse after release.
- DONE with i_working=1 for 5 cycles -> FSM stays in DRAIN; o_done rises on the cycle after i_working falls.
- Run edge during DRAIN, plus async reset mid-loop -> PC=0, o_done=0, o_delay=4'hF, all outputs at reset values.
